// File: rtl/acct_checker.sv
// acct_checker: per-master access enforcement in front of the peripheral crossbar.
// A request is checked against the master's acc_ctrl slice when it is accepted.
// Permitted requests are forwarded and their response is relayed upstream.
// Denied requests get a local error response and are recorded in a violation log.
module acct_checker #(
    parameter int NB_PERIPHERALS = 8,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int PIDX_W         = (NB_PERIPHERALS > 1) ? $clog2(NB_PERIPHERALS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [4*NB_PERIPHERALS-1:0] acc_ctrl_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ADDR_W-1:0]           req_addr_i,
    input  logic                        req_we_i,
    input  logic [DATA_W-1:0]           req_wdata_i,
    input  logic [PIDX_W-1:0]           req_pidx_i,
    output logic                        fwd_valid_o,
    input  logic                        fwd_ready_i,
    output logic [ADDR_W-1:0]           fwd_addr_o,
    output logic                        fwd_we_o,
    output logic [DATA_W-1:0]           fwd_wdata_o,
    input  logic                        rsp_valid_i,
    input  logic [DATA_W-1:0]           rsp_rdata_i,
    input  logic                        rsp_err_i,
    output logic                        rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        rsp_err_o,
    input  logic                        viol_clr_i,
    output logic                        viol_valid_o,
    output logic [ADDR_W-1:0]           viol_addr_o,
    output logic [PIDX_W-1:0]           viol_pidx_o,
    output logic                        viol_we_o,
    output logic [15:0]                 viol_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        WAIT_RSP,
        RESP,
        DENY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                viol_valid_q, viol_valid_d;
    logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;
    logic [PIDX_W-1:0]   viol_pidx_q, viol_pidx_d;
    logic                viol_we_q, viol_we_d;
    logic [15:0]         viol_cnt_q, viol_cnt_d;

    logic                allowed;
    logic                deny_evt;

    // Bits 3:2 of every nibble carry no permission in this stage.
    logic                unused_acc;
    assign unused_acc = ^acc_ctrl_i;

    // Permission lookup: an out-of-range index matches no nibble and is denied.
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        allowed = 1'b0;
        for (int p = 0; p < NB_PERIPHERALS; p++) begin
            if (req_pidx_i == PIDX_W'(p)) begin
                allowed = req_we_i ? acc_ctrl_i[4*p+1] : acc_ctrl_i[4*p];
            end
        end
    end

    assign deny_evt = (state_q == IDLE) && req_valid_i && !allowed;

    // Transaction FSM next state and capture of request / response fields.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    state_d = allowed ? FWD : DENY;
                end
            end
            FWD: begin
                if (fwd_ready_i) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_valid_i) begin
                    rdata_d = rsp_rdata_i;
                    err_d   = rsp_err_i;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            DENY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Violation log: a clear is applied first so a same-cycle denial starts a fresh record.
    always_comb begin
        viol_valid_d = viol_valid_q;
        viol_addr_d  = viol_addr_q;
        viol_pidx_d  = viol_pidx_q;
        viol_we_d    = viol_we_q;
        viol_cnt_d   = viol_cnt_q;
        if (viol_clr_i) begin
            viol_valid_d = 1'b0;
            viol_addr_d  = '0;
            viol_pidx_d  = '0;
            viol_we_d    = 1'b0;
            viol_cnt_d   = '0;
        end
        if (deny_evt) begin
            if (!viol_valid_d) begin
                viol_valid_d = 1'b1;
                viol_addr_d  = req_addr_i;
                viol_pidx_d  = req_pidx_i;
                viol_we_d    = req_we_i;
            end
            if (viol_cnt_d != 16'hFFFF) viol_cnt_d = viol_cnt_d + 16'd1;
        end
    end

    // State, latched transaction fields and log registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            viol_valid_q <= 1'b0;
            viol_addr_q  <= '0;
            viol_pidx_q  <= '0;
            viol_we_q    <= 1'b0;
            viol_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            viol_valid_q <= viol_valid_d;
            viol_addr_q  <= viol_addr_d;
            viol_pidx_q  <= viol_pidx_d;
            viol_we_q    <= viol_we_d;
            viol_cnt_q   <= viol_cnt_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign fwd_valid_o  = (state_q == FWD);
    assign fwd_addr_o   = addr_q;
    assign fwd_we_o     = we_q;
    assign fwd_wdata_o  = wdata_q;
    assign rsp_valid_o  = (state_q == RESP) || (state_q == DENY);
    assign rsp_rdata_o  = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err_o    = ((state_q == RESP) && err_q) || (state_q == DENY);
    assign viol_valid_o = viol_valid_q;
    assign viol_addr_o  = viol_addr_q;
    assign viol_pidx_o  = viol_pidx_q;
    assign viol_we_o    = viol_we_q;
    assign viol_cnt_o   = viol_cnt_q;

endmodule

// File: tb/tb_acct_checker.sv
// Self-checking bench for acct_checker: directed cases plus randomized traffic
// against a permission/log reference model, with a scoreboard-driven monitor.
module tb_acct_checker;

    localparam int NB = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [4*NB-1:0] acc_ctrl_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i;
    logic            req_we_i;
    logic [DW-1:0]   req_wdata_i;
    logic [PW-1:0]   req_pidx_i;
    logic            fwd_valid_o;
    logic            fwd_ready_i;
    logic [AW-1:0]   fwd_addr_o;
    logic            fwd_we_o;
    logic [DW-1:0]   fwd_wdata_o;
    logic            rsp_valid_i;
    logic [DW-1:0]   rsp_rdata_i;
    logic            rsp_err_i;
    logic            rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic            viol_clr_i;
    logic            viol_valid_o;
    logic [AW-1:0]   viol_addr_o;
    logic [PW-1:0]   viol_pidx_o;
    logic            viol_we_o;
    logic [15:0]     viol_cnt_o;

    acct_checker #(
        .NB_PERIPHERALS(NB),
        .ADDR_W        (AW),
        .DATA_W        (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .acc_ctrl_i  (acc_ctrl_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .req_pidx_i  (req_pidx_i),
        .fwd_valid_o (fwd_valid_o),
        .fwd_ready_i (fwd_ready_i),
        .fwd_addr_o  (fwd_addr_o),
        .fwd_we_o    (fwd_we_o),
        .fwd_wdata_o (fwd_wdata_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_rdata_i (rsp_rdata_i),
        .rsp_err_i   (rsp_err_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .viol_clr_i  (viol_clr_i),
        .viol_valid_o(viol_valid_o),
        .viol_addr_o (viol_addr_o),
        .viol_pidx_o (viol_pidx_o),
        .viol_we_o   (viol_we_o),
        .viol_cnt_o  (viol_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } fwd_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    fwd_t fwd_q[$];
    rsp_t rsp_q[$];

    logic [3:0]    nib [NB];
    logic          m_vv;
    logic [AW-1:0] m_vaddr;
    logic [PW-1:0] m_vpidx;
    logic          m_vwe;
    int            m_cnt;

    function automatic logic [4*NB-1:0] pack_acc();
        logic [4*NB-1:0] v;
        for (int p = 0; p < NB; p++) v[4*p +: 4] = nib[p];
        return v;
    endfunction

    task automatic set_all(input logic [3:0] v);
        for (int p = 0; p < NB; p++) nib[p] = v;
        acc_ctrl_i = pack_acc();
    endtask

    task automatic model_clear();
        m_vv    = 1'b0;
        m_vaddr = '0;
        m_vpidx = '0;
        m_vwe   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_viol_valid"}, viol_valid_o, m_vv);
        check({tag, "_viol_addr"},  viol_addr_o,  m_vaddr);
        check({tag, "_viol_pidx"},  viol_pidx_o,  m_vpidx);
        check({tag, "_viol_we"},    viol_we_o,    m_vwe);
        check({tag, "_viol_cnt"},   viol_cnt_o,   m_cnt);
    endtask

    // ---------------- monitor ----------------
    logic stalled;
    fwd_t held;
    fwd_t mf;
    rsp_t mr;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stalled = 1'b0;
        end else begin
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid_o, 1'b0);
                end else begin
                    mr = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_o, mr.rdata);
                    check("rsp_err",   rsp_err_o,   mr.err);
                end
            end
            if (fwd_valid_o) begin
                if (stalled) begin
                    check("fwd_addr_stable",  fwd_addr_o,  held.addr);
                    check("fwd_we_stable",    fwd_we_o,    held.we);
                    check("fwd_wdata_stable", fwd_wdata_o, held.wdata);
                end
                check("req_ready_busy", req_ready_o, 1'b0);
                if (fwd_ready_i) begin
                    stalled = 1'b0;
                    if (fwd_q.size() == 0) begin
                        check("fwd_unexpected", fwd_valid_o, 1'b0);
                    end else begin
                        mf = fwd_q.pop_front();
                        check("fwd_addr",  fwd_addr_o,  mf.addr);
                        check("fwd_we",    fwd_we_o,    mf.we);
                        check("fwd_wdata", fwd_wdata_o, mf.wdata);
                    end
                end else begin
                    stalled    = 1'b1;
                    held.addr  = fwd_addr_o;
                    held.we    = fwd_we_o;
                    held.wdata = fwd_wdata_o;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issues one request and, if it should be forwarded, plays the downstream side.
    task automatic issue(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                         input logic [PW-1:0] pidx, input logic [DW-1:0] rd, input logic rerr,
                         input int stall, input bit flip, input bit clr);
        bit allowed;
        int n;
        n = 0;
        while (!req_ready_o) begin
            @(posedge clk_i); #1;
            n++;
            if (n > 50) begin
                check("ready_timeout", req_ready_o, 1'b1);
                return;
            end
        end
        allowed = 1'b0;
        if (pidx < NB) allowed = nib[pidx][we];
        req_addr_i  = a;
        req_we_i    = we;
        req_wdata_i = wd;
        req_pidx_i  = pidx;
        req_valid_i = 1'b1;
        viol_clr_i  = clr;
        if (allowed) begin
            fwd_q.push_back('{a, we, wd});
            rsp_q.push_back('{rd, rerr});
        end else begin
            rsp_q.push_back('{'0, 1'b1});
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        viol_clr_i  = 1'b0;
        req_addr_i  = $urandom;
        req_pidx_i  = PW'($urandom_range(0, 7));

        if (clr) model_clear();
        if (!allowed) begin
            if (!m_vv) begin
                m_vv    = 1'b1;
                m_vaddr = a;
                m_vpidx = pidx;
                m_vwe   = we;
            end
            if (m_cnt < 65535) m_cnt++;
        end
        check_log("accept");

        if (allowed) begin
            check("fwd_valid_T1", fwd_valid_o, 1'b1);
            fwd_ready_i = 1'b0;
            for (int i = 0; i < stall; i++) begin
                rsp_valid_i = 1'($urandom_range(0, 1));
                rsp_rdata_i = $urandom;
                if (flip && i == 1) begin
                    for (int p = 0; p < NB; p++) nib[p] = ~nib[p];
                    acc_ctrl_i = pack_acc();
                end
                @(posedge clk_i); #1;
            end
            rsp_valid_i = 1'b0;
            fwd_ready_i = 1'b1;
            @(posedge clk_i); #1;
            fwd_ready_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1;
            end
            rsp_valid_i = 1'b1;
            rsp_rdata_i = rd;
            rsp_err_i   = rerr;
            @(posedge clk_i); #1;
            rsp_valid_i = 1'b0;
            rsp_rdata_i = $urandom;
            rsp_err_i   = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
        end else begin
            check("fwd_valid_deny", fwd_valid_o, 1'b0);
            check("deny_err_T1",    rsp_err_o,   1'b1);
            @(posedge clk_i); #1;
            check("ready_T2", req_ready_o, 1'b1);
        end
    endtask

    task automatic clear_log();
        viol_clr_i = 1'b1;
        @(posedge clk_i); #1;
        viol_clr_i = 1'b0;
        model_clear();
        check_log("clear");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_we_i    = 1'b0;
        req_wdata_i = '0;
        req_pidx_i  = '0;
        fwd_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_rdata_i = '0;
        rsp_err_i   = 1'b0;
        viol_clr_i  = 1'b0;
        set_all(4'h0);
        model_clear();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_fwd_valid", fwd_valid_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_err",   rsp_err_o,   1'b0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check_log("rst");

        // Read allowed on peripheral 2 only.
        nib[2] = 4'b0001;
        acc_ctrl_i = pack_acc();
        issue(32'h1000, 1'b0, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0, 0, 1'b0, 1'b0);
        // Write to the same peripheral is denied and logged.
        issue(32'h1000, 1'b1, 32'h5555AAAA, 3'd2, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        check("deny_addr_1000", viol_addr_o, 32'h1000);
        check("deny_cnt_1",     viol_cnt_o,  16'd1);
        clear_log();

        // Highest valid index forwards; out-of-range indices deny.
        set_all(4'hF);
        issue(32'h2000, 1'b0, 32'h0,      3'd5, 32'h12345678, 1'b1, 1, 1'b0, 1'b0);
        issue(32'h2004, 1'b1, 32'hDEAD01, 3'd5, 32'h0,        1'b0, 0, 1'b0, 1'b0);
        issue(32'h3000, 1'b0, 32'h0,      3'd7, 32'h0,        1'b0, 0, 1'b0, 1'b0);
        issue(32'h3004, 1'b1, 32'h1,      3'd6, 32'h0,        1'b0, 0, 1'b0, 1'b0);
        clear_log();

        // Two denials: first record sticks, counter reaches 2.
        set_all(4'h0);
        issue(32'h10, 1'b0, 32'h0, 3'd1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        issue(32'h20, 1'b1, 32'h0, 3'd3, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        check("two_deny_addr", viol_addr_o, 32'h10);
        check("two_deny_cnt",  viol_cnt_o,  16'd2);
        clear_log();

        // Backpressure with permission revoked mid-flight.
        set_all(4'h3);
        issue(32'h4000, 1'b1, 32'hA5A5A5A5, 3'd0, 32'h0, 1'b0, 5, 1'b1, 1'b0);

        // Clear coinciding with a new denial keeps the new record.
        set_all(4'h0);
        issue(32'h30, 1'b0, 32'h0, 3'd4, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        issue(32'h40, 1'b1, 32'h0, 3'd2, 32'h0, 1'b0, 0, 1'b0, 1'b1);
        check("clr_deny_addr", viol_addr_o, 32'h40);
        check("clr_deny_cnt",  viol_cnt_o,  16'd1);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int p = 0; p < NB; p++) nib[p] = 4'($urandom);
                acc_ctrl_i = pack_acc();
            end
            issue($urandom, 1'($urandom_range(0, 1)), $urandom, PW'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // Saturation: preload the counter near its ceiling, then keep denying.
        set_all(4'h0);
        force dut.viol_cnt_q = 16'hFFFD;
        #1;
        release dut.viol_cnt_q;
        m_cnt = 65533;
        for (int k = 0; k < 4; k++) begin
            issue(32'h5000 + k, 1'b0, 32'h0, 3'd1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        end
        check("sat_cnt", viol_cnt_o, 16'hFFFF);

        // Reset while waiting for the downstream response; the late response is dropped.
        set_all(4'hF);
        req_addr_i  = 32'h6000;
        req_we_i    = 1'b0;
        req_pidx_i  = 3'd1;
        req_valid_i = 1'b1;
        fwd_q.push_back('{32'h6000, 1'b0, req_wdata_i});
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        fwd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        fwd_ready_i = 1'b0;
        check("wr_ready_busy", req_ready_o, 1'b0);
        rst_ni = 1'b0;
        #2;
        check("async_rst_ready", req_ready_o, 1'b1);
        check("async_rst_cnt",   viol_cnt_o,  16'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_clear();
        rsp_valid_i = 1'b1;
        rsp_rdata_i = 32'hBAD0BAD0;
        @(posedge clk_i); #1;
        rsp_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("post_rst_ready", req_ready_o, 1'b1);
        check_log("post_rst");

        check("rsp_queue_empty", rsp_q.size(), 0);
        check("fwd_queue_empty", fwd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
